// File: rtl/axil_reg_pkg.sv
// Shared types for the AXI4-Lite register responder: response codes, FSM
// state encodings and the register data width.
package axil_reg_pkg;

  localparam int REG_W = 32;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register array with a byte-strobed write port and a combinational read port.
// Indices at or beyond NUM_REGS read as zero and are never written.
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [REG_W-1:0]   wr_data,
  input  logic [REG_W/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [REG_W-1:0]   rd_data
);

  logic [REG_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < REG_W/8; b++) begin
            if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = regs[i];
    end
  end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register responder with independent write and read FSMs.
// Define AXIL_REG_RESPONDER_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [REG_W-1:0]  WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [REG_W-1:0]  RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int IDX_W = ADDR_W - 2;

`ifdef AXIL_REG_RESPONDER_SLVERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  function automatic resp_t resp_for(input logic [IDX_W-1:0] idx);
    return idx_ok(idx) ? RESP_OKAY : OOR_RESP;
  endfunction

  w_state_t           w_state;
  r_state_t           r_state;
  logic               live_p0, live_p1;
  logic [IDX_W-1:0]   aw_idx_q;
  logic [REG_W-1:0]   wdata_q;
  logic [3:0]         wstrb_q;
  resp_t              bresp_q;
  resp_t              rresp_q;
  logic [REG_W-1:0]   rdata_q;

  logic [IDX_W-1:0]   aw_idx, ar_idx, wr_idx;
  logic [REG_W-1:0]   wr_data, rd_data;
  logic [3:0]         wr_strb;
  logic               aw_hs, w_hs, ar_hs, commit, we;
  logic               unused_ok;

  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign aw_idx = AWADDR[ADDR_W-1:2];
  assign ar_idx = ARADDR[ADDR_W-1:2];

  // Readies come purely from registered state, gated until two edges after reset release.
  assign AWREADY = live_p1 && (w_state == W_IDLE || w_state == W_HAVE_DATA);
  assign WREADY  = live_p1 && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
  assign BVALID  = (w_state == W_RESP);
  assign BRESP   = bresp_q;
  assign ARREADY = live_p1 && (r_state == R_IDLE);
  assign RVALID  = (r_state == R_RESP);
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  always_comb begin
    commit  = 1'b0;
    wr_idx  = aw_idx;
    wr_data = WDATA;
    wr_strb = WSTRB;
    unique case (w_state)
      W_IDLE:      commit = aw_hs && w_hs;
      W_HAVE_ADDR: begin
        commit = w_hs;
        wr_idx = aw_idx_q;
      end
      W_HAVE_DATA: begin
        commit  = aw_hs;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
      end
      W_RESP:      commit = 1'b0;
    endcase
  end

  assign we = commit && idx_ok(wr_idx);

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .we      (we),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_idx  (ar_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      live_p0 <= 1'b0;
      live_p1 <= 1'b0;
    end else begin
      live_p0 <= 1'b1;
      live_p1 <= live_p0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (commit) begin
            bresp_q <= resp_for(wr_idx);
            w_state <= W_RESP;
          end else if (aw_hs) begin
            aw_idx_q <= aw_idx;
            w_state  <= W_HAVE_ADDR;
          end else if (w_hs) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
            w_state <= W_HAVE_DATA;
          end
        end
        W_HAVE_ADDR, W_HAVE_DATA: begin
          if (commit) begin
            bresp_q <= resp_for(wr_idx);
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bresp_q <= RESP_OKAY;
            w_state <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read data is captured at the AR edge, so a same-edge write is not yet visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q <= rd_data;
            rresp_q <= resp_for(ar_idx);
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            r_state <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized, self-checking bench for axil_reg_responder against a register-array model.
// Honours AXIL_REG_RESPONDER_SLVERR_EN for out-of-range response expectations.
module tb_axil_reg_responder;

  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 4;
  localparam int TMO      = 40;

`ifdef AXIL_REG_RESPONDER_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic              ACLK, ARESETN;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [2:0]        AWPROT, ARPROT;
  logic              AWVALID, AWREADY, WVALID, WREADY;
  logic [31:0]       WDATA, RDATA;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP, RRESP;
  logic              BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] mdl [NUM_REGS];

  axil_reg_responder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a) / 4;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] a);
    return (idx_of(a) < NUM_REGS) ? 2'b00 : OOR_RESP;
  endfunction

  function automatic logic [31:0] exp_read(input logic [ADDR_W-1:0] a);
    return (idx_of(a) < NUM_REGS) ? mdl[idx_of(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (idx_of(a) < NUM_REGS) mdl[idx_of(a)] = (mdl[idx_of(a)] & ~mask) | (d & mask);
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int aw_c, output int w_c, output int bv_cnt);
    int awc, wc;
    fork
      begin
        repeat (aw_dly) begin @(posedge ACLK); #1; end
        AWADDR = a; AWPROT = 3'($urandom); AWVALID = 1'b1;
        for (int n = 0; n < TMO && !AWREADY; n++) begin @(posedge ACLK); #1; end
        check("awready_seen", AWREADY, 1);
        awc = cyc;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
      end
      begin
        repeat (w_dly) begin @(posedge ACLK); #1; end
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        for (int n = 0; n < TMO && !WREADY; n++) begin @(posedge ACLK); #1; end
        check("wready_seen", WREADY, 1);
        wc = cyc;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
      end
    join
    aw_c = awc;
    w_c = wc;
    check("bvalid_latency", BVALID, 1);
    resp = BRESP;
    bv_cnt = 0;
    for (int i = 0; i < b_dly; i++) begin
      if (BVALID) bv_cnt++;
      check("bresp_stable", BRESP, resp);
      @(posedge ACLK); #1;
    end
    check("bvalid_hold", BVALID, 1);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 0);
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    ARADDR = a; ARPROT = 3'($urandom); ARVALID = 1'b1;
    for (int n = 0; n < TMO && !ARREADY; n++) begin @(posedge ACLK); #1; end
    check("arready_seen", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check("rvalid_latency", RVALID, 1);
    data = RDATA;
    resp = RRESP;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge ACLK); #1;
      check("rdata_stable", RDATA, data);
      check("rresp_stable", RRESP, resp);
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    check("rvalid_drop", RVALID, 0);
    check("rdata_idle_zero", RDATA, 0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] r;
    int ac, wc, bc;
    axi_write(a, d, s, aw_dly, w_dly, b_dly, r, ac, wc, bc);
    check("bresp", r, exp_resp(a));
    model_write(a, d, s);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int r_dly);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(a, r_dly, d, r);
    check("rdata", d, exp_read(a));
    check("rresp", r, exp_resp(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int ac, wc, bc;

    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_rdata", RDATA, 0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("rdy_edge1_aw", AWREADY, 0);
    check("rdy_edge1_ar", ARREADY, 0);
    @(posedge ACLK); #1;
    check("rdy_edge2_aw", AWREADY, 1);
    check("rdy_edge2_w", WREADY, 1);
    check("rdy_edge2_ar", ARREADY, 1);

    for (int i = 0; i < 4; i++) do_write(ADDR_W'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(ADDR_W'(4 * i), 0);

    do_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 1, 0);
    do_write(6'h04, 32'h11223344, 4'b0101, 1, 0, 0);
    axi_read(6'h04, 0, d, r);
    check("strb_merge", d, 32'hAA22CC44);
    do_write(6'h04, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    do_read(6'h04, 1);

    axi_write(6'h08, 32'h5A, 4'hF, 3, 0, 5, r, ac, wc, bc);
    check("w_before_aw", wc < ac, 1);
    check("bvalid_held_5", bc, 5);
    check("bresp_late_aw", r, 0);
    model_write(6'h08, 32'h5A, 4'hF);
    axi_read(6'h08, 2, d, r);
    check("read_5a", d, 32'h5A);

    do_write(6'h10, 32'hDEAD, 4'hF, 0, 0, 0);
    do_read(6'h10, 0);
    for (int i = 0; i < 4; i++) do_read(ADDR_W'(4 * i), 0);

    do_write(6'h00, 32'h1, 4'hF, 0, 0, 0);
    fork
      axi_write(6'h00, 32'h77, 4'hF, 0, 0, 0, r, ac, wc, bc);
      begin
        logic [31:0] rd;
        logic [1:0]  rr;
        axi_read(6'h00, 0, rd, rr);
        check("same_edge_old_value", rd, 32'h1);
      end
    join
    model_write(6'h00, 32'h77, 4'hF);
    do_read(6'h00, 0);

    AWADDR = 6'h04; AWVALID = 1'b1;
    for (int n = 0; n < TMO && !AWREADY; n++) begin @(posedge ACLK); #1; end
    check("mid_rst_awready", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    ARESETN = 1'b0;
    #1;
    check("mid_rst_bvalid", BVALID, 0);
    check("mid_rst_awready_low", AWREADY, 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    bc = 0;
    for (int i = 0; i < 4; i++) begin
      if (BVALID) bc++;
      @(posedge ACLK); #1;
    end
    check("mid_rst_no_bvalid", bc, 0);
    for (int i = 0; i < 4; i++) do_read(ADDR_W'(4 * i), 0);
    do_write(6'h04, 32'h12345678, 4'hF, 0, 2, 1);
    do_read(6'h04, 0);

    for (int t = 0; t < 80; t++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, NUM_REGS + 1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end
    for (int i = 0; i < NUM_REGS; i++) do_read(ADDR_W'(4 * i), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_reg_responder.md
AXIL_REG_RESPONDER -- requirements
Module: axil_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning byte-address width of AWADDR/ARADDR.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning number of implemented 32-bit registers at byte offsets 0x0, 0x4, and so on.
REQ-003 SHALL have ports ACLK in 1 (sole clock) and ARESETN in 1 (reset, asynchronous, active-low).
REQ-004 SHALL have write-address ports AWADDR in ADDR_W, AWPROT in 3 (ignored), AWVALID in 1 and AWREADY out 1.
REQ-005 SHALL have write-data ports WDATA in 32, WSTRB in 4, WVALID in 1 and WREADY out 1.
REQ-006 SHALL have write-response ports BRESP out 2, BVALID out 1 and BREADY in 1.
REQ-007 SHALL have read-address ports ARADDR in ADDR_W, ARPROT in 3 (ignored), ARVALID in 1 and ARREADY out 1.
REQ-008 SHALL have read-data ports RDATA out 32, RRESP out 2, RVALID out 1 and RREADY in 1.

Function
REQ-009 SHALL be an AXI4-Lite responder with independent write and read channels; AW and W may arrive in either order or in the same cycle.
REQ-010 Write FSM SHALL have states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
REQ-011 In W_IDLE, AWREADY and WREADY SHALL be 1.
REQ-012 In W_HAVE_ADDR, WREADY SHALL be 1 and AWREADY 0.
REQ-013 In W_HAVE_DATA, AWREADY SHALL be 1 and WREADY 0.
REQ-014 In W_RESP, BVALID SHALL be 1 and both readies SHALL be 0.
REQ-015 All READY and VALID outputs SHALL decode from registered state; there SHALL be no combinational path from any input VALID or READY to any output.
REQ-016 Once both AW and W have handshaken, the register write SHALL commit at that edge and BVALID SHALL assert the next cycle.
REQ-017 When AW and W handshake in the same cycle from W_IDLE, the FSM SHALL go directly to W_RESP.
REQ-018 BVALID and BRESP SHALL hold stable until BREADY=1; the FSM SHALL then return to W_IDLE on the following edge.
REQ-019 Writes SHALL be byte-masked: for each set bit i of WSTRB, register byte i SHALL be updated; WSTRB=0 SHALL leave the register unchanged and return OKAY.
REQ-020 Register index SHALL be ADDR[ADDR_W-1:2]; ADDR[1:0] SHALL be ignored.
REQ-021 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_RESP (RVALID=1, ARREADY=0).
REQ-022 On an AR handshake, RDATA and RRESP SHALL be latched and RVALID SHALL assert the next cycle (one-cycle latency).
REQ-023 RDATA and RRESP SHALL hold stable until RREADY=1.
REQ-024 When a read and a write to the same register complete their address phase at the same edge, the read SHALL return the pre-write value.
REQ-025 Out-of-range addresses (index >= NUM_REGS) SHALL never modify state; their response SHALL follow REQ-030.
REQ-026 RDATA SHALL be 0 whenever RVALID=0.

Reset
REQ-027 With ARESETN=0, all registers SHALL be 0x00000000 and both FSMs SHALL be in their IDLE states.
REQ-028 With ARESETN=0, AWREADY, WREADY, ARREADY, BVALID and RVALID SHALL be 0, and BRESP, RRESP and RDATA SHALL be 0.
REQ-029 Readies SHALL first assert on the second ACLK edge after ARESETN deasserts; reset asserted mid-transaction SHALL abort it with no partial register update and no pending response.

Configuration
REQ-030 With macro AXIL_REG_RESPONDER_SLVERR_EN defined, out-of-range accesses SHALL return RRESP or BRESP = SLVERR (2'b10) and RDATA=0; without the macro, they SHALL return OKAY, reads SHALL give 0 and writes SHALL be silently dropped.

Structure
REQ-031 Package axil_reg_pkg SHALL hold the resp_t constants (OKAY, SLVERR), the write and read FSM state enums, and the register data-width constant 32.
REQ-032 Sub-module axil_reg_bank SHALL hold the register array with byte-strobed write and combinational read ports; axil_reg_responder SHALL own both FSMs and channel logic.

Verification
REQ-033 Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four -> data 0x1..0x4, all BRESP and RRESP OKAY.
REQ-034 Write 0xAABBCCDD to 0x4, then write 0x11223344 with WSTRB=4'b0101 -> read 0x4 returns 0xAA22CC44.
REQ-035 Assert WVALID 3 cycles before AWVALID (addr 0x8, data 0x5A) while holding BREADY=0 for 5 cycles -> WREADY handshakes first, BVALID held 5 cycles, read 0x8 = 0x5A.
REQ-036 Write 0xDEAD to 0x10, then read 0x10 -> with the macro, BRESP and RRESP = SLVERR; without it, OKAY with RDATA=0; registers 0..3 unchanged in both builds.
REQ-037 Issue AR 0x0 in the same cycle as AW and W 0x0 with data 0x77, the register holding 0x1 -> RDATA=0x1, and a subsequent read returns 0x77.
REQ-038 Drop ARESETN for 1 cycle after the AW handshake but before W -> BVALID is never asserted, all registers read 0, and a new write completes normally.
